// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp bit positions and the per-approach lamp decoder
// used by the traffic sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_ALLRED = 3'd0,
        PH_PREP   = 3'd1,
        PH_GREEN  = 3'd2,
        PH_YELLOW = 3'd3,
        PH_FLASH  = 3'd4
    } phase_e;

    localparam int GRN = 2;
    localparam int YEL = 1;
    localparam int RED = 0;

    // Returns the active-low {green, yellow, red} triple for one approach.
    function automatic logic [2:0] lamp_bits(input phase_e ph, input logic served,
                                             input logic flash_on);
        logic [2:0] lit;
        lit = '0;
        case (ph)
            PH_FLASH:  lit[YEL] = flash_on;
            PH_PREP:   begin
                lit[RED] = 1'b1;
                lit[YEL] = served;
            end
            PH_GREEN:  begin
                lit[GRN] = served;
                lit[RED] = ~served;
            end
            PH_YELLOW: begin
                lit[YEL] = served;
                lit[RED] = ~served;
            end
            default:   lit[RED] = 1'b1;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/traffic_seq_n_tick_gen.sv
// Timing-tick enable: one-cycle pulse every TICK_DIV clocks, the first one
// TICK_DIV clocks after reset release.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk50M,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_seq_n.sv
// N-approach traffic light sequencer with demand skipping and a flashing
// yellow night mode; all outputs come straight from registers.
module traffic_seq_n
    import traffic_pkg::*;
#(
    parameter int N_WAYS   = 3,
    parameter int TICK_DIV = 50000000,
    parameter int T_ALLRED = 5,
    parameter int T_PREP   = 2,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 2,
    parameter int SKIP_EN  = 1,
    localparam int WAY_W   = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic                  clk50M,
    input  logic                  rst_n,
    input  logic [N_WAYS-1:0]     req,
    input  logic                  night,
    output logic [3*N_WAYS-1:0]   lamp_n,
    output logic [WAY_W-1:0]      way,
    output logic [2:0]            phase
);

    localparam int D_ALLRED = (T_ALLRED < 1) ? 1 : T_ALLRED;
    localparam int D_PREP   = (T_PREP   < 1) ? 1 : T_PREP;
    localparam int D_GREEN  = (T_GREEN  < 1) ? 1 : T_GREEN;
    localparam int D_YELLOW = (T_YELLOW < 1) ? 1 : T_YELLOW;
    localparam int MAX_AB   = (D_ALLRED > D_PREP) ? D_ALLRED : D_PREP;
    localparam int MAX_CD   = (D_GREEN > D_YELLOW) ? D_GREEN : D_YELLOW;
    localparam int MAX_D    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = $clog2(MAX_D + 1);

    localparam logic [3*N_WAYS-1:0] LAMP_ALLRED = {N_WAYS{3'b110}};

    phase_e                phase_q, phase_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_WAYS-1:0]     pending_q, pending_d;
    logic                  flash_q, flash_d;
    logic [3*N_WAYS-1:0]   lamp_q, lamp_d;

    logic                  tick;
    logic                  sel_found;
    logic [WAY_W-1:0]      sel_way;
    logic [WAY_W-1:0]      cand;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
        return (w == WAY_W'(N_WAYS - 1)) ? '0 : w + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] last_tick(input phase_e ph);
        case (ph)
            PH_ALLRED: return CNT_W'(D_ALLRED - 1);
            PH_PREP:   return CNT_W'(D_PREP - 1);
            PH_GREEN:  return CNT_W'(D_GREEN - 1);
            PH_YELLOW: return CNT_W'(D_YELLOW - 1);
            default:   return '0;
        endcase
    endfunction

    // Round-robin search for the first pending approach after the current one.
    always_comb begin
        sel_found = 1'b0;
        sel_way   = way_q;
        cand      = way_q;
        for (int i = 0; i < N_WAYS; i++) begin
            cand = next_way(cand);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_way   = cand;
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        way_d     = way_q;
        cnt_d     = cnt_q;
        flash_d   = flash_q;
        pending_d = pending_q | req;
        lamp_d    = '1;

        if (tick) begin
            if (phase_q == PH_FLASH) begin
                if (!night) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                    flash_d = 1'b0;
                end else begin
                    flash_d = ~flash_q;
                end
            end else if (cnt_q != last_tick(phase_q)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                case (phase_q)
                    PH_ALLRED: begin
                        if (night) begin
                            phase_d = PH_FLASH;
                            flash_d = 1'b1;
                        end else if (SKIP_EN == 0) begin
                            phase_d = PH_PREP;
                            way_d   = next_way(way_q);
                        end else if (sel_found) begin
                            phase_d = PH_PREP;
                            way_d   = sel_way;
                        end
                    end
                    PH_PREP: begin
                        phase_d = PH_GREEN;
                        // A request present on the entry cycle keeps the flag set.
                        pending_d[way_q] = req[way_q];
                    end
                    PH_GREEN:  phase_d = PH_YELLOW;
                    default:   phase_d = PH_ALLRED;
                endcase
            end
        end

        for (int k = 0; k < N_WAYS; k++) begin
            lamp_d[3*k +: 3] = lamp_bits(phase_d, (way_d == WAY_W'(k)), flash_d);
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_ALLRED;
            way_q     <= WAY_W'(N_WAYS - 1);
            cnt_q     <= '0;
            pending_q <= '0;
            flash_q   <= 1'b0;
            lamp_q    <= LAMP_ALLRED;
        end else begin
            phase_q   <= phase_d;
            way_q     <= way_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            flash_q   <= flash_d;
            lamp_q    <= lamp_d;
        end
    end

    assign lamp_n = lamp_q;
    assign way    = way_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_seq_n.sv
// Directed bench for traffic_seq_n: two instances (SKIP_EN=0 and 1) share inputs.
module tb_traffic_seq_n;

    localparam logic [8:0] ALL_RED  = 9'b110_110_110;
    localparam logic [8:0] ALL_YEL  = 9'b101_101_101;
    localparam logic [8:0] ALL_OFF  = 9'b111_111_111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       night;
    logic [8:0] lamp0, lamp1, lamp_s;
    logic [1:0] way0, way1, way_s;
    logic [2:0] ph0, ph1, ph_s;
    logic       sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    traffic_seq_n #(
        .N_WAYS(3), .TICK_DIV(4), .T_ALLRED(5), .T_PREP(2),
        .T_GREEN(10), .T_YELLOW(2), .SKIP_EN(0)
    ) dut0 (
        .clk50M(clk), .rst_n(rst_n), .req(req), .night(night),
        .lamp_n(lamp0), .way(way0), .phase(ph0)
    );

    traffic_seq_n #(
        .N_WAYS(3), .TICK_DIV(4), .T_ALLRED(5), .T_PREP(2),
        .T_GREEN(10), .T_YELLOW(2), .SKIP_EN(1)
    ) dut1 (
        .clk50M(clk), .rst_n(rst_n), .req(req), .night(night),
        .lamp_n(lamp1), .way(way1), .phase(ph1)
    );

    assign lamp_s = sel ? lamp1 : lamp0;
    assign way_s  = sel ? way1  : way0;
    assign ph_s   = sel ? ph1   : ph0;

    function automatic logic [8:0] exp_lamp(input logic [2:0] ph, input logic [1:0] w);
        logic [8:0] r;
        logic [2:0] t;
        for (int k = 0; k < 3; k++) begin
            t = 3'b110;
            if (k == int'(w)) begin
                case (ph)
                    3'd1: t = 3'b100;
                    3'd2: t = 3'b011;
                    3'd3: t = 3'b101;
                    default: t = 3'b110;
                endcase
            end
            r[3*k +: 3] = t;
        end
        return r;
    endfunction

    function automatic int n_active(input logic [8:0] l);
        int n;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (!l[3*k+2] || (!l[3*k+1] && l[3*k])) n++;
        end
        return n;
    endfunction

    // Mutual exclusion of green / yellow-without-red outside FLASH, every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ph0 !== 3'd4 && n_active(lamp0) > 1) begin
                errors++;
                $display("FAIL excl_dut0 t=%0t lamp_n=%b active=%0d required<=1", $time, lamp0, n_active(lamp0));
            end
            if (ph1 !== 3'd4 && n_active(lamp1) > 1) begin
                errors++;
                $display("FAIL excl_dut1 t=%0t lamp_n=%b active=%0d required<=1", $time, lamp1, n_active(lamp1));
            end
        end
    end

    task automatic wait_change(input int limit, output int cyc, output bit changed);
        logic [2:0] p0;
        logic [1:0] w0;
        p0 = ph_s;
        w0 = way_s;
        cyc = 0;
        changed = 1'b0;
        while (!changed && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (ph_s !== p0 || way_s !== w0) changed = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        night = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        night = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ph0 !== 3'd0) begin errors++; $display("FAIL rst_phase0 got=%0d want=0", ph0); end
        checks++; if (way0 !== 2'd2) begin errors++; $display("FAIL rst_way0 got=%0d want=2", way0); end
        checks++; if (lamp0 !== ALL_RED) begin errors++; $display("FAIL rst_lamp0 got=%b want=%b", lamp0, ALL_RED); end
        checks++; if (ph1 !== 3'd0) begin errors++; $display("FAIL rst_phase1 got=%0d want=0", ph1); end
        checks++; if (way1 !== 2'd2) begin errors++; $display("FAIL rst_way1 got=%0d want=2", way1); end
        checks++; if (lamp1 !== ALL_RED) begin errors++; $display("FAIL rst_lamp1 got=%b want=%b", lamp1, ALL_RED); end
    endtask

    task automatic test_rotation();
        int  ec[12] = '{8, 40, 8, 20, 8, 40, 8, 20, 8, 40, 8, 20};
        int  ep[12] = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        int  ew[12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
        int  cyc;
        bit  ch;
        sel = 1'b0;
        do_reset();
        wait_change(40, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd1 || way_s !== 2'd0) begin
            errors++; $display("FAIL rot_first cyc=%0d ph=%0d way=%0d want cyc=20 ph=1 way=0", cyc, ph_s, way_s);
        end
        for (int i = 0; i < 12; i++) begin
            wait_change(ec[i] + 10, cyc, ch);
            checks++;
            if (cyc != ec[i] || ph_s !== 3'(ep[i]) || way_s !== 2'(ew[i])) begin
                errors++;
                $display("FAIL rot_step%0d cyc=%0d ph=%0d way=%0d want cyc=%0d ph=%0d way=%0d",
                         i, cyc, ph_s, way_s, ec[i], ep[i], ew[i]);
            end
            checks++;
            if (lamp_s !== exp_lamp(3'(ep[i]), 2'(ew[i]))) begin
                errors++;
                $display("FAIL rot_lamp%0d got=%b want=%b", i, lamp_s, exp_lamp(3'(ep[i]), 2'(ew[i])));
            end
        end
    endtask

    task automatic test_skip();
        int cyc;
        bit ch;
        sel = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        req = 3'b100;
        @(negedge clk);
        req = 3'b000;
        wait_change(40, cyc, ch);
        checks++;
        if (cyc != 14 || ph_s !== 3'd1 || way_s !== 2'd2) begin
            errors++; $display("FAIL skip_prep2 cyc=%0d ph=%0d way=%0d want cyc=14 ph=1 way=2", cyc, ph_s, way_s);
        end
        wait_change(20, cyc, ch);
        wait_change(50, cyc, ch);
        wait_change(20, cyc, ch);
        checks++;
        if (cyc != 8 || ph_s !== 3'd0 || way_s !== 2'd2) begin
            errors++; $display("FAIL skip_allred cyc=%0d ph=%0d way=%0d want cyc=8 ph=0 way=2", cyc, ph_s, way_s);
        end
        wait_change(60, cyc, ch);
        checks++;
        if (ch || ph_s !== 3'd0 || way_s !== 2'd2 || lamp_s !== ALL_RED) begin
            errors++; $display("FAIL skip_idle changed=%0d ph=%0d way=%0d lamp=%b want no change ph=0 way=2", ch, ph_s, way_s, lamp_s);
        end
        req = 3'b001;
        @(negedge clk);
        req = 3'b000;
        wait_change(40, cyc, ch);
        checks++;
        if (cyc != 19 || ph_s !== 3'd1 || way_s !== 2'd0) begin
            errors++; $display("FAIL skip_prep0 cyc=%0d ph=%0d way=%0d want cyc=19 ph=1 way=0", cyc, ph_s, way_s);
        end
    endtask

    task automatic test_night();
        int cyc;
        bit ch;
        sel = 1'b0;
        do_reset();
        wait_change(40, cyc, ch);
        wait_change(20, cyc, ch);
        repeat (10) @(negedge clk);
        night = 1'b1;
        wait_change(50, cyc, ch);
        checks++;
        if (cyc != 30 || ph_s !== 3'd3 || way_s !== 2'd0) begin
            errors++; $display("FAIL night_green_len cyc=%0d ph=%0d way=%0d want cyc=30 ph=3 way=0", cyc, ph_s, way_s);
        end
        wait_change(20, cyc, ch);
        wait_change(30, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd4 || way_s !== 2'd0 || lamp_s !== ALL_YEL) begin
            errors++; $display("FAIL night_flash_in cyc=%0d ph=%0d way=%0d lamp=%b want cyc=20 ph=4 way=0 lamp=%b", cyc, ph_s, way_s, lamp_s, ALL_YEL);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ph_s !== 3'd4 || lamp_s !== ALL_OFF) begin
            errors++; $display("FAIL night_flash_off ph=%0d lamp=%b want ph=4 lamp=%b", ph_s, lamp_s, ALL_OFF);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ph_s !== 3'd4 || lamp_s !== ALL_YEL) begin
            errors++; $display("FAIL night_flash_on ph=%0d lamp=%b want ph=4 lamp=%b", ph_s, lamp_s, ALL_YEL);
        end
        night = 1'b0;
        wait_change(10, cyc, ch);
        checks++;
        if (cyc != 4 || ph_s !== 3'd0 || way_s !== 2'd0 || lamp_s !== ALL_RED) begin
            errors++; $display("FAIL night_exit cyc=%0d ph=%0d way=%0d lamp=%b want cyc=4 ph=0 way=0 lamp=%b", cyc, ph_s, way_s, lamp_s, ALL_RED);
        end
        wait_change(30, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd1 || way_s !== 2'd1) begin
            errors++; $display("FAIL night_resume cyc=%0d ph=%0d way=%0d want cyc=20 ph=1 way=1", cyc, ph_s, way_s);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ch;
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) wait_change(50, cyc, ch);
        checks++;
        if (ph_s !== 3'd2 || way_s !== 2'd1) begin
            errors++; $display("FAIL rmid_green1 ph=%0d way=%0d want ph=2 way=1", ph_s, way_s);
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (lamp_s !== ALL_RED || ph_s !== 3'd0 || way_s !== 2'd2) begin
            errors++; $display("FAIL rmid_async lamp=%b ph=%0d way=%0d want lamp=%b ph=0 way=2", lamp_s, ph_s, way_s, ALL_RED);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_change(40, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd1 || way_s !== 2'd0) begin
            errors++; $display("FAIL rmid_restart cyc=%0d ph=%0d way=%0d want cyc=20 ph=1 way=0", cyc, ph_s, way_s);
        end
    endtask

    task automatic test_hold_req();
        int cyc;
        bit ch;
        sel = 1'b1;
        do_reset();
        req = 3'b010;
        wait_change(40, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd1 || way_s !== 2'd1) begin
            errors++; $display("FAIL hold_prep1 cyc=%0d ph=%0d way=%0d want cyc=20 ph=1 way=1", cyc, ph_s, way_s);
        end
        wait_change(20, cyc, ch);
        repeat (2) @(negedge clk);
        req = 3'b000;
        wait_change(50, cyc, ch);
        checks++;
        if (cyc != 38 || ph_s !== 3'd3 || way_s !== 2'd1) begin
            errors++; $display("FAIL hold_yellow cyc=%0d ph=%0d way=%0d want cyc=38 ph=3 way=1", cyc, ph_s, way_s);
        end
        wait_change(20, cyc, ch);
        wait_change(30, cyc, ch);
        checks++;
        if (cyc != 20 || ph_s !== 3'd1 || way_s !== 2'd1) begin
            errors++; $display("FAIL hold_again cyc=%0d ph=%0d way=%0d want cyc=20 ph=1 way=1", cyc, ph_s, way_s);
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_rotation();
        test_skip();
        test_night();
        test_reset_mid();
        test_hold_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_seq_n.md
TRAFFIC_SEQ_N -- requirements
Module: traffic_seq_n

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_WAYS, 3: number of approaches, legal range 2..8.
- TICK_DIV, 50000000: clk50M cycles per timing tick (1 s at 50 MHz).
- T_ALLRED, 5: all-red duration, in ticks.
- T_PREP, 2: red+yellow duration, in ticks.
- T_GREEN, 10: green duration, in ticks.
- T_YELLOW, 2: yellow duration, in ticks.
- SKIP_EN, 1: 1 = skip approaches with no pending request.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk50M, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- req, in, N_WAYS: per-approach demand pulse or level; synchronous to clk50M.
- night, in, 1: flashing-yellow mode request.
- lamp_n, out, 3*N_WAYS: active-low lamps; approach k uses bits [3k+2:3k] = green, yellow, red.
- way, out, max(1,clog2(N_WAYS)): index of the approach being served.
- phase, out, 3: current phase code.

Function
REQ-003 tick_gen SHALL emit a 1-cycle tick every TICK_DIV cycles; the first tick comes TICK_DIV cycles after reset release.
REQ-004 Phases SHALL be ALLRED=0, PREP=1, GREEN=2, YELLOW=3, FLASH=4; a phase SHALL last exactly its duration in ticks; a duration of 0 SHALL be treated as 1.
REQ-005 The sequence SHALL be ALLRED -> PREP -> GREEN -> YELLOW -> ALLRED; the phase counter SHALL clear on every phase change.
REQ-006 Lamps for the served approach SHALL be: PREP red+yellow, GREEN green, YELLOW yellow. All other approaches, and ALLRED, SHALL show red only.
REQ-007 Lamp encoding SHALL be active-low: a lit lamp drives 0.
REQ-008 Each req bit SHALL set a sticky pending[k] flag. pending[k] SHALL clear on entry to GREEN for approach k; if req[k] is high in that same cycle, the set SHALL win.
REQ-009 At ALLRED exit with SKIP_EN=1, the next approach SHALL be the first k with pending[k] set, searching round-robin from way+1 mod N_WAYS. If no flag is pending, ALLRED SHALL repeat with way unchanged.
REQ-010 With SKIP_EN=0, ALLRED exit SHALL always go to way+1 mod N_WAYS; pending is still tracked but ignored for selection.
REQ-011 night SHALL be sampled only at ALLRED exit; if high, the next phase SHALL be FLASH instead of PREP.
REQ-012 In FLASH, all yellow lamps SHALL toggle on every tick, starting lit, and all red and green lamps SHALL be off.
REQ-013 FLASH SHALL exit on the first tick with night=0, going to a full ALLRED with all lamps red; way is unchanged.
REQ-014 night asserted during PREP, GREEN or YELLOW SHALL NOT shorten or alter those phases.
REQ-015 There SHALL never be a cycle in which two approaches show green or yellow-without-red simultaneously, except in FLASH.
REQ-016 lamp_n, way and phase SHALL be registered outputs with no combinational path from any input.
REQ-017 The phase counter width SHALL be clog2 of the maximum duration plus 1; the tick_gen counter width SHALL be clog2(TICK_DIV).

Reset
REQ-018 While rst_n=0:
- phase SHALL be ALLRED;
- way SHALL be N_WAYS-1, so the first served approach is 0;
- pending, the tick counter and the phase counter SHALL be 0;
- lamp_n SHALL show red only on all approaches.
REQ-019 Reset asserted mid-phase SHALL force the REQ-018 state asynchronously. After release, a full T_ALLRED SHALL elapse before any PREP.

Structure
REQ-020 Package traffic_pkg SHALL hold the phase codes and the lamp bit-position constants (GRN=2, YEL=1, RED=0).
REQ-021 Sub-module tick_gen SHALL produce the tick enable; all logic SHALL run on clk50M with no derived clocks.

Verification (TICK_DIV=4, N_WAYS=3, default durations)
REQ-022 SKIP_EN=0, req=0 -> ways served 0,1,2,0. Each cycle spans 19 ticks (5+2+10+2); the lamp pattern matches REQ-006 on every tick.
REQ-023 SKIP_EN=1, pulse req[2] once during ALLRED -> way 2 is served next; then ALLRED repeats with way=2 until another req arrives.
REQ-024 night=1 raised mid-GREEN -> GREEN and YELLOW complete; after ALLRED the block enters FLASH and yellows toggle each tick. night=0 -> 5-tick ALLRED, then PREP on the next approach.
REQ-025 rst_n pulsed low mid-GREEN of way 1 -> lamp_n immediately shows all red. After release, a 5-tick ALLRED precedes PREP of way 0.
REQ-026 req[1] held high through way-1 GREEN entry -> pending[1] stays set; with SKIP_EN=1, way 1 is served again at its next round-robin turn.
REQ-027 A bench assertion SHALL check REQ-015 on every cycle in all scenarios.
